// File: rtl/fetch_decode_reg.sv
// -----------------------------------------------------------------------------
// fetch_decode_reg
//   Pipeline register between the fetch and decode stages. Fetched
//   instructions arrive over a valid/ready handshake and sit in a two-entry
//   skid buffer made of a main slot and a skid slot. The instruction in the
//   main slot is split into opcode, rd, rs1, rs2 and an unextended immediate.
//   A flush turns everything in flight into bubbles.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   one-cycle flush pulse from branch resolution
//   in_valid   in   fetch presents in_instr/in_pc
//   in_ready   out  buffer can accept (straight from a register)
//   in_instr   in   fetched instruction
//   in_pc      in   PC of in_instr
//   out_valid  out  decoded fields are valid
//   out_ready  in   decode consumes (low = stall)
//   out_opcode out  opcode field, NOP_OPCODE on a bubble
//   out_rd     out  destination register, 0 on a bubble
//   out_rs1    out  source register 1, 0 on a bubble
//   out_rs2    out  source register 2 (overlaps the immediate MSBs), 0 on a bubble
//   out_imm    out  raw immediate, sign extension happens in decode, 0 on a bubble
//   out_pc     out  PC of the presented instruction, 0 on a bubble
// -----------------------------------------------------------------------------
module fetch_decode_reg #(
  parameter int                      INSTR_WIDTH    = 32,
  parameter int                      IMM_WIDTH      = 19,
  parameter int                      REG_ADDR_WIDTH = 4,
  parameter int                      OPCODE_WIDTH   = 5,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE     = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_WIDTH-1:0]    in_instr,
  input  logic [INSTR_WIDTH-1:0]    in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_WIDTH-1:0]   out_opcode,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [IMM_WIDTH-1:0]      out_imm,
  output logic [INSTR_WIDTH-1:0]    out_pc
);

  // Field positions, packed from the MSB down; rs2 deliberately reuses the
  // top bits of the immediate.
  localparam int OP_LSB  = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int RD_LSB  = OP_LSB - REG_ADDR_WIDTH;
  localparam int RS1_LSB = RD_LSB - REG_ADDR_WIDTH;
  localparam int RS2_LSB = IMM_WIDTH - REG_ADDR_WIDTH;

  if (OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH != INSTR_WIDTH) begin : g_width_check
    $fatal(1, "fetch_decode_reg: instruction fields do not add up to INSTR_WIDTH");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  logic                   main_valid_q, main_valid_d;
  logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
  logic [INSTR_WIDTH-1:0] main_pc_q,    main_pc_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [INSTR_WIDTH-1:0] skid_pc_q,    skid_pc_d;

  state_e state;
  logic   in_xfer;
  logic   out_xfer;

  // The occupancy state is fully encoded by the two valid bits; skid is
  // never valid without main, so the remaining combination cannot occur.
  always_comb begin
    if (!main_valid_q)      state = EMPTY;
    else if (!skid_valid_q) state = ONE;
    else                    state = FULL;
  end

  // in_ready comes only from the skid register so it never has a
  // combinational path from out_ready.
  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_valid_d = 1'b1;
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end else if (in_xfer) begin
          // Decode stalled: park the newcomer behind main.
          skid_valid_d = 1'b1;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
          skid_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase

    // Flush wins over any capture in the same cycle; an output transfer on
    // that edge has already been seen by decode, so it needs no undo.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // Output decode with combinational bubble masking.
  always_comb begin
    out_opcode = NOP_OPCODE;
    out_rd     = '0;
    out_rs1    = '0;
    out_rs2    = '0;
    out_imm    = '0;
    out_pc     = '0;
    if (main_valid_q) begin
      out_opcode = main_instr_q[OP_LSB  +: OPCODE_WIDTH];
      out_rd     = main_instr_q[RD_LSB  +: REG_ADDR_WIDTH];
      out_rs1    = main_instr_q[RS1_LSB +: REG_ADDR_WIDTH];
      out_rs2    = main_instr_q[RS2_LSB +: REG_ADDR_WIDTH];
      out_imm    = main_instr_q[IMM_WIDTH-1:0];
      out_pc     = main_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_decode_reg.sv
module tb_fetch_decode_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [18:0] out_imm;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order queue holding at most two instructions.
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];

  fetch_decode_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_imm    (out_imm),
    .out_pc     (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock, updating the model from the inputs now applied.
  // Inputs are driven and outputs sampled around the falling edge.
  task automatic cycle();
    bit accept;
    bit emit;
    accept = in_valid && (q_instr.size() < 2);
    emit   = (q_instr.size() > 0) && out_ready;
    if (flush) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (emit) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (accept) begin
        q_instr.push_back(in_instr);
        q_pc.push_back(in_pc);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_opcode !== 5'd0 || out_pc !== 32'd0) begin errors++; $display("FAIL reset_fields op=%h pc=%h want 0", out_opcode, out_pc); end
    rst_n = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release v=%b r=%b want v=0 r=1", out_valid, in_ready); end

    // Fill to FULL with decode stalled, then reset between clock edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = $urandom();
      in_pc    = 32'h40 + 32'(i * 4);
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_before_reset r=%b v=%b want r=0 v=1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    q_instr.delete();
    q_pc.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_opcode !== 5'd0 || out_imm !== 19'd0) begin errors++; $display("FAIL async_reset_fields op=%h imm=%h want 0", out_opcode, out_imm); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_reset_empty v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_single_decode();
    idle_inputs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h1A903039;
    in_pc     = 32'h100;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", out_valid); end
    checks++; if (out_opcode !== 5'd3 || out_rd !== 4'd5 || out_rs1 !== 4'd2 || out_rs2 !== 4'd0)
      begin errors++; $display("FAIL single_regs op=%0d rd=%0d rs1=%0d rs2=%0d want 3 5 2 0", out_opcode, out_rd, out_rs1, out_rs2); end
    checks++; if (out_imm !== 19'h03039 || out_pc !== 32'h100)
      begin errors++; $display("FAIL single_imm_pc imm=%h pc=%h want 03039 100", out_imm, out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b0 || out_opcode !== 5'd0 || out_rd !== 4'd0 || out_imm !== 19'd0 || out_pc !== 32'd0)
      begin errors++; $display("FAIL single_bubble v=%b op=%h rd=%h imm=%h pc=%h want all 0", out_valid, out_opcode, out_rd, out_imm, out_pc); end
  endtask

  task automatic test_negative_imm();
    idle_inputs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h089F2BCF;
    in_pc     = 32'h200;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_opcode !== 5'd1 || out_rd !== 4'd1 || out_rs1 !== 4'd3 || out_rs2 !== 4'd14)
      begin errors++; $display("FAIL negimm_regs op=%0d rd=%0d rs1=%0d rs2=%0d want 1 1 3 14", out_opcode, out_rd, out_rs1, out_rs2); end
    checks++; if (out_imm !== 19'h72BCF || out_pc !== 32'h200)
      begin errors++; $display("FAIL negimm_imm imm=%h pc=%h want 72bcf 200", out_imm, out_pc); end
    cycle();
  endtask

  task automatic test_stall_skid();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom();
    b = $urandom();
    idle_inputs();
    in_valid = 1'b1;
    in_instr = a;
    in_pc    = 32'h0;
    cycle();
    in_instr = b;
    in_pc    = 32'h4;
    cycle();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready_full got=%b want=0", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_imm !== a[18:0])
      begin errors++; $display("FAIL skid_hold v=%b pc=%h imm=%h want 1 0 %h", out_valid, out_pc, out_imm, a[18:0]); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_opcode !== b[31:27])
      begin errors++; $display("FAIL skid_second v=%b pc=%h op=%h want 1 4 %h", out_valid, out_pc, out_opcode, b[31:27]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_in_ready_one got=%b want=1", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    // Flush from FULL while an instruction is offered.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = $urandom();
      in_pc    = 32'h300 + 32'(i * 4);
      cycle();
    end
    in_instr = 32'hDEADBEEF;
    in_pc    = 32'h999;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_opcode !== 5'd0)
      begin errors++; $display("FAIL flush_full v=%b r=%b op=%h want 0 1 0", out_valid, in_ready, out_opcode); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_no_emit got=%b want=0", out_valid); end

    // Flush from ONE while an instruction would otherwise be accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = $urandom();
    in_pc     = 32'h500;
    cycle();
    in_instr = 32'hCAFEF00D;
    in_pc    = 32'h504;
    flush    = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_one_ready got=%b want=1", in_ready); end
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0)
      begin errors++; $display("FAIL flush_one_discard v=%b pc=%h want 0 0", out_valid, out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_no_emit got=%b want=0", out_valid); end
  endtask

  // random_mode=0: back-to-back stream with decode always ready.
  // random_mode=1: random valid/ready/flush traffic.
  task automatic test_stream(input int n, input bit random_mode);
    int          emitted;
    int          stream_errs;
    logic [31:0] h;
    logic [31:0] p;
    bit          exp_v;
    logic [4:0]  exp_op;
    idle_inputs();
    emitted     = 0;
    stream_errs = 0;
    for (int i = 0; i < n + 3; i++) begin
      if (i >= n) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
      end else if (random_mode) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 24) == 0);
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
      end
      in_instr = $urandom();
      in_pc    = 32'h1000 + 32'(i * 4);

      exp_v  = (q_instr.size() > 0);
      h      = exp_v ? q_instr[0] : 32'd0;
      p      = exp_v ? q_pc[0]    : 32'd0;
      exp_op = exp_v ? 5'((h >> 27) & 32'h1F) : 5'd0;

      checks++;
      if (in_ready !== (q_instr.size() < 2) || out_valid !== exp_v) begin
        errors++; stream_errs++;
        $display("FAIL stream_hs i=%0d r=%b v=%b want r=%b v=%b", i, in_ready, out_valid, q_instr.size() < 2, exp_v);
      end
      checks++;
      if (out_opcode !== exp_op || out_rd !== 4'((h >> 23) & 32'hF) || out_rs1 !== 4'((h >> 19) & 32'hF) ||
          out_rs2 !== 4'((h >> 15) & 32'hF) || out_imm !== 19'(h % 32'h80000) || out_pc !== p) begin
        errors++; stream_errs++;
        $display("FAIL stream_fields i=%0d op=%h rd=%h rs1=%h rs2=%h imm=%h pc=%h want instr=%h pc=%h",
                 i, out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc, h, p);
      end
      if (out_valid === 1'b1 && out_ready) emitted++;
      cycle();
    end
    if (!random_mode) begin
      checks++;
      if (emitted !== n) begin errors++; $display("FAIL stream_count got=%0d want=%0d", emitted, n); end
    end
    $display("stream mode=%0d items=%0d emitted=%0d errors=%0d", random_mode, n, emitted, stream_errs);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_decode();
    test_negative_imm();
    test_stall_skid();
    test_flush();
    test_stream(100, 1'b0);
    test_stream(300, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Splits each instruction into opcode, rd, rs1, rs2 and a raw IMM_WIDTH immediate. The raw immediate feeds the decode-stage immediate sign extender.
- Supports a branch/exception flush that converts everything in flight into bubbles.

Parameters:
- INSTR_WIDTH, 32, instruction and PC width.
- IMM_WIDTH, 19, raw immediate field width (instr[IMM_WIDTH-1:0]).
- REG_ADDR_WIDTH, 4, register specifier width.
- OPCODE_WIDTH, 5, opcode field width.
- NOP_OPCODE, 5'd0, opcode driven on outputs when no valid instruction is presented.
- Constraint: OPCODE_WIDTH + 2*REG_ADDR_WIDTH + IMM_WIDTH == INSTR_WIDTH (elaboration-time check; fatal on mismatch).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush, one cycle pulse, from branch resolution.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept (registered).
- in_instr  in  INSTR_WIDTH  fetched instruction.
- in_pc  in  INSTR_WIDTH  PC of in_instr.
- out_valid  out  1  decode fields valid.
- out_ready  in  1  decode stage consumes (low = stall).
- out_opcode  out  OPCODE_WIDTH  instr[31:27].
- out_rd  out  REG_ADDR_WIDTH  instr[26:23].
- out_rs1  out  REG_ADDR_WIDTH  instr[22:19].
- out_rs2  out  REG_ADDR_WIDTH  instr[18:15] (overlaps imm MSBs by format).
- out_imm  out  IMM_WIDTH  instr[18:0], unextended.
- out_pc  out  INSTR_WIDTH  PC of presented instruction.

Behaviour:
- Storage: main slot (main_valid, main_instr, main_pc) and skid slot (skid_valid, skid_instr, skid_pc).
- States:
  - EMPTY: !main_valid.
  - ONE: main_valid && !skid_valid.
  - FULL: both valid.
  - skid_valid is never 1 while main_valid is 0.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Port derivation:
  - in_ready = !skid_valid, taken from the register. It is never combinationally dependent on out_ready.
  - out_valid = main_valid.
  - Fields decode from main_instr.
- Transitions without flush:
  - EMPTY + input: capture into main -> ONE.
  - ONE + input + output: main <= input -> ONE.
  - ONE + output only -> EMPTY.
  - ONE + input, no output: input captured into skid -> FULL.
  - FULL + output: main <= skid, skid cleared -> ONE. No input is accepted, because in_ready=0.
  - FULL, no output: hold.
- Latency: one cycle from input transfer to out_valid in EMPTY. Full throughput (1/cycle) with out_ready held high.
- Ordering: strict FIFO order; no instruction is dropped or duplicated.
- Bubble masking: when out_valid=0, out_opcode=NOP_OPCODE and out_rd/rs1/rs2/imm/pc are all 0. The outputs are combinationally masked.
- Flush:
  - At the edge where flush=1, main_valid and skid_valid clear.
  - A simultaneous input transfer is discarded; flush has priority.
  - A simultaneous output transfer completes normally from the decode stage's view.
  - Next cycle: EMPTY, in_ready=1.
- Reset (rst_n low, asynchronous):
  - main_valid=0, skid_valid=0, all data registers 0.
  - Outputs read in_ready=1 (while in reset and after release), out_valid=0, out_opcode=NOP_OPCODE, other fields 0.
  - Reset mid-operation discards all buffered instructions immediately, without waiting for clk.
- No arithmetic is performed on the instruction or PC; width slicing only. Sign extension is not done here.

Test Plan:
- Reset: assert rst_n=0 mid-stream with FULL state -> out_valid=0, out_opcode=0, in_ready=1 asynchronously. Release -> state stays EMPTY.
- Single decode: in_instr=0x1A903039, in_pc=0x100, out_ready=1 -> next cycle out_valid=1, opcode=3, rd=5, rs1=2, rs2=0, imm=19'h03039 (12345), pc=0x100.
- Negative immediate: in_instr=0x089F2BCF -> opcode=1, rd=1, rs1=3, rs2=14, imm=19'h72BCF (-54321 as 19-bit).
- Stall/skid: out_ready=0, send A (pc 0x0) then B (pc 0x4) -> in_ready=0 after B. Raise out_ready -> A then B on consecutive cycles, in_ready=1 when B is in main.
- Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction is never emitted.
- Streaming: 100 back-to-back random instructions, out_ready=1 -> one output per cycle, in order, 1-cycle latency. Random out_ready toggling -> scoreboard order and fields match.
